// File: rtl/stage_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, defaults and the
// instruction used to represent an empty F/D slot.
package stage_fetch_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam int          IMEM_AW_DEFAULT  = 12;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;
    localparam logic [31:0] NOP_INSN         = 32'd0;

endpackage

// File: rtl/adder32.sv
// General-purpose 32-bit adder with carry-in, carry-out and signed-overflow
// flags, shared by datapath blocks that need a plain binary add.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        overflow
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

    // Signed overflow: operands agree in sign but the result does not.
    assign overflow = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/stage_fetch_fd_latch.sv
// F/D pipeline register slice. A load captures a fetched instruction and
// marks it valid; a squash only clears valid so the payload fields hold.
module stage_fetch_fd_latch
    import stage_fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        squash,
    input  logic [31:0] insn_d,
    input  logic [31:0] pc_plus_4_d,
    output logic [31:0] insn,
    output logic [31:0] pc_plus_4,
    output logic        valid
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            insn      <= NOP_INSN;
            pc_plus_4 <= 32'd0;
            valid     <= 1'b0;
        end else if (load) begin
            insn      <= insn_d;
            pc_plus_4 <= pc_plus_4_d;
            valid     <= 1'b1;
        end else if (squash) begin
            valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/stage_fetch.sv
// Fetch-stage PC sequencer: steers the PC from execute redirects, hazard
// stalls or sequential fetch, and feeds the F/D latch and synchronous ROM.
module stage_fetch
    import stage_fetch_pkg::*;
#(
    parameter int          IMEM_AW  = IMEM_AW_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               ex_redirect,
    input  logic [31:0]        ex_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_q,
    output logic [31:0]        pc,
    output logic [31:0]        fd_insn,
    output logic [31:0]        fd_pc_plus_4,
    output logic               fd_valid,
    output logic               dx_flush,
    output logic [CNT_W-1:0]   redirect_count,
    output logic [CNT_W-1:0]   stall_count
);

    fetch_state_t state;
    logic [31:0]  pc_inc;
    logic [31:0]  next_pc;
    logic         fd_load;
    logic         fd_squash;
    logic         carry_unused;
    logic         overflow_unused;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] count);
        return (&count) ? count : count + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    adder32 u_pc_inc (
        .a        (pc),
        .b        (32'd1),
        .cin      (1'b0),
        .sum      (pc_inc),
        .cout     (carry_unused),
        .overflow (overflow_unused)
    );

    // Redirect beats stall: the stalled instruction is on the wrong path anyway.
    always_comb begin
        next_pc   = pc;
        fd_load   = 1'b0;
        fd_squash = 1'b0;
        if (state == RUN) begin
            if (ex_redirect) begin
                next_pc   = ex_target;
                fd_squash = 1'b1;
            end else if (!stall) begin
                next_pc = pc_inc;
                fd_load = 1'b1;
            end
        end
    end

    // The ROM registers its address, so presenting next_pc now yields the
    // instruction at the new pc on the following cycle.
    assign imem_addr = next_pc[IMEM_AW-1:0];
    assign dx_flush  = (state == RUN) && ex_redirect;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            redirect_count <= '0;
            stall_count    <= '0;
        end else if (state == BOOT) begin
            state <= RUN;
        end else begin
            pc <= next_pc;
            if (ex_redirect) begin
                redirect_count <= sat_inc(redirect_count);
            end else if (stall) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end

    stage_fetch_fd_latch u_fd_latch (
        .clock       (clock),
        .reset       (reset),
        .load        (fd_load),
        .squash      (fd_squash),
        .insn_d      (imem_q),
        .pc_plus_4_d (pc_inc),
        .insn        (fd_insn),
        .pc_plus_4   (fd_pc_plus_4),
        .valid       (fd_valid)
    );

endmodule

// File: tb/tb_stage_fetch.sv
// Self-checking bench for stage_fetch: directed scenarios plus random
// redirect/stall traffic compared against a behavioural fetch model.
module tb_stage_fetch;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic [11:0] imem_addr;
    logic [31:0] imem_q;
    logic [31:0] pc;
    logic [31:0] fd_insn;
    logic [31:0] fd_pc_plus_4;
    logic        fd_valid;
    logic        dx_flush;
    logic [15:0] redirect_count;
    logic [15:0] stall_count;

    int n_compared;
    int n_mismatched;

    logic [31:0] rom [0:4095];

    bit          m_run;
    logic [31:0] m_pc;
    logic [31:0] m_insn;
    logic [31:0] m_pc1;
    logic        m_valid;
    int          m_rc;
    int          m_sc;

    stage_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .ex_redirect    (ex_redirect),
        .ex_target      (ex_target),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .pc             (pc),
        .fd_insn        (fd_insn),
        .fd_pc_plus_4   (fd_pc_plus_4),
        .fd_valid       (fd_valid),
        .dx_flush       (dx_flush),
        .redirect_count (redirect_count),
        .stall_count    (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clock) imem_q <= rom[imem_addr];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_pc    = 32'd0;
        m_insn  = 32'd0;
        m_pc1   = 32'd0;
        m_valid = 1'b0;
        m_rc    = 0;
        m_sc    = 0;
    endtask

    // One clock edge of the fetch stage as described by its behaviour.
    task automatic model_edge(input logic s, input logic r, input logic [31:0] t);
        if (!m_run) begin
            m_run = 1'b1;
        end else if (r) begin
            m_pc    = t;
            m_valid = 1'b0;
            m_rc    = (m_rc == 65535) ? 65535 : m_rc + 1;
        end else if (s) begin
            m_sc = (m_sc == 65535) ? 65535 : m_sc + 1;
        end else begin
            m_insn  = rom[m_pc[11:0]];
            m_pc1   = m_pc + 32'd1;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd1;
        end
    endtask

    task automatic check_regs();
        check_output("pc", pc, m_pc);
        check_output("fd_insn", fd_insn, m_insn);
        check_output("fd_pc_plus_4", fd_pc_plus_4, m_pc1);
        check_output("fd_valid", {31'd0, fd_valid}, {31'd0, m_valid});
        check_output("redirect_count", {16'd0, redirect_count}, m_rc);
        check_output("stall_count", {16'd0, stall_count}, m_sc);
    endtask

    task automatic apply_stimulus(input logic s, input logic r, input logic [31:0] t, input bit do_check);
        logic [31:0] exp_next;
        stall       = s;
        ex_redirect = r;
        ex_target   = t;
        #1;
        if (!m_run)  exp_next = m_pc;
        else if (r)  exp_next = t;
        else if (s)  exp_next = m_pc;
        else         exp_next = m_pc + 32'd1;
        if (do_check) begin
            check_output("imem_addr", {20'd0, imem_addr}, {20'd0, exp_next[11:0]});
            check_output("dx_flush", {31'd0, dx_flush}, {31'd0, (m_run && r)});
        end
        @(posedge clock);
        model_edge(s, r, t);
        #1;
        if (do_check) check_regs();
    endtask

    initial begin
        logic [31:0] pc_seq [0:3];
        n_compared   = 0;
        n_mismatched = 0;
        for (int i = 0; i < 4096; i++) rom[i] = i + 100;
        pc_seq[0] = 32'd0; pc_seq[1] = 32'd1; pc_seq[2] = 32'd2; pc_seq[3] = 32'd3;

        stall       = 1'b0;
        ex_redirect = 1'b0;
        ex_target   = 32'd0;
        reset       = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_regs();
        check_output("reset_dx_flush", {31'd0, dx_flush}, 32'd0);
        check_output("reset_imem_addr", {20'd0, imem_addr}, 32'd0);

        // Boot cycle then sequential fetch from the reset PC.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);
            check_output("pc_seq", pc, pc_seq[i]);
            if (i == 1) check_output("first_insn", fd_insn, 32'd100);
        end
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);
        check_output("pc_at_5", pc, 32'd5);

        // Redirect to 40, then the target instruction arrives a cycle later.
        apply_stimulus(1'b0, 1'b1, 32'd40, 1'b1);
        check_output("redir_pc", pc, 32'd40);
        check_output("redir_bubble", {31'd0, fd_valid}, 32'd0);
        check_output("redir_count1", {16'd0, redirect_count}, 32'd1);
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);
        check_output("target_insn", fd_insn, 32'd140);

        // Stall for three cycles at pc=7.
        apply_stimulus(1'b0, 1'b1, 32'd6, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 32'd0, 1'b1);
        check_output("stall_pc", pc, 32'd7);
        check_output("stall_count3", {16'd0, stall_count}, 32'd3);
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);
        check_output("resume_pc", pc, 32'd8);
        check_output("resume_insn", fd_insn, 32'd107);

        // Redirect wins over a simultaneous stall.
        apply_stimulus(1'b1, 1'b1, 32'd12, 1'b1);
        check_output("both_pc", pc, 32'd12);
        check_output("both_stall_count", {16'd0, stall_count}, 32'd3);

        // PC wrap at the top of the address space.
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);
        check_output("wrap_pc", pc, 32'd0);

        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(3) == 0), ($urandom_range(3) == 0), $urandom, 1'b1);
        end

        // Asynchronous reset in the middle of a redirect cycle.
        stall       = 1'b0;
        ex_redirect = 1'b1;
        ex_target   = 32'd77;
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_regs();
        check_output("async_dx_flush", {31'd0, dx_flush}, 32'd0);
        check_output("async_imem_addr", {20'd0, imem_addr}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        apply_stimulus(1'b1, 1'b1, 32'd99, 1'b1);
        check_output("boot_pc", pc, 32'd0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(($urandom_range(3) == 0), ($urandom_range(3) == 0), $urandom, 1'b1);
        end

        // Saturate the redirect counter.
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 65541; i++) apply_stimulus(1'b0, 1'b1, $urandom, 1'b0);
        check_regs();
        check_output("redir_saturate", {16'd0, redirect_count}, 32'h0000_FFFF);
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
